// File: rtl/branch_resolve_sequencer.sv
// In-order retirement controller for speculative branch tags: records dispatched tags,
// accepts out-of-order resolutions, retires oldest-first. Optional sticky err via SEQ_CHECK_EN.
module branch_resolve_sequencer #(
  parameter int TAG_W       = 5,
  parameter int DEPTH       = 4,
  parameter int RECOVER_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc1,
  input  logic                       alloc2,
  input  logic [TAG_W-1:0]           alloc_tag1,
  input  logic [TAG_W-1:0]           alloc_tag2,
  input  logic                       res_valid,
  input  logic [TAG_W-1:0]           res_tag,
  input  logic                       res_miss,
  output logic                       alloc_ok,
  output logic                       stall,
  output logic                       prsuccess,
  output logic                       prmiss,
  output logic [TAG_W-1:0]           head_tag,
  output logic [TAG_W-1:0]           tagregfix,
  output logic [TAG_W-1:0]           kill_mask,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SEQ_CHECK_EN
  ,
  output logic                       err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RC_W  = (RECOVER_LAT > 1) ? $clog2(RECOVER_LAT) : 1;

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rcnt_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] done_q, miss_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             normal, head_done, pop_hit, pop_miss, admit, do_alloc;
  logic [DEPTH-1:0] ent_valid, res_hit;
  logic [TAG_W-1:0] kill_all;
  logic [PTR_W-1:0] slot2;
  int               n_alloc;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Restore value for the tag generator: step the one-hot ring back by one position.
  function automatic logic [TAG_W-1:0] rot_right(input logic [TAG_W-1:0] t);
    return {t[0], t[TAG_W-1:1]};
  endfunction

  always_comb begin
    normal    = (state_q == NORMAL);
    ent_valid = '0;
    kill_all  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ((i - int'(head_q) + DEPTH) % DEPTH) < int'(count_q);
      if (ent_valid[i]) kill_all = kill_all | tag_q[i];
    end
    head_done = (count_q != '0) && done_q[head_q];
    pop_hit   = normal && head_done && !miss_q[head_q];
    pop_miss  = normal && head_done && miss_q[head_q];
    // A retiring head frees its slot in the same cycle, so it counts toward admission.
    admit     = (int'(count_q) - int'(head_done) + int'(alloc1) + int'(alloc2)) <= DEPTH;
    alloc_ok  = normal && admit;
    do_alloc  = alloc_ok && !pop_miss && (alloc1 || alloc2);
    n_alloc   = int'(alloc1) + int'(alloc2);
    slot2     = alloc1 ? ptr_add(tail_q, 1) : tail_q;
    res_hit   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      res_hit[i] = normal && !pop_miss && res_valid && ent_valid[i] && !done_q[i]
                   && (tag_q[i] == res_tag);
    end
    stall     = !normal;
    prsuccess = pop_hit;
    prmiss    = pop_miss;
    head_tag  = (pop_hit || pop_miss) ? tag_q[head_q] : '0;
    tagregfix = pop_miss ? rot_right(tag_q[head_q]) : '0;
    kill_mask = pop_miss ? kill_all : '0;
    count     = count_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:  if (pop_miss) state_d = RECOVER;
      RECOVER: if (rcnt_q == RC_W'(RECOVER_LAT - 1)) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= normal ? '0 : rcnt_q + RC_W'(1);
    end
  end

  // Queue control: a mispredicted head flushes everything and discards same-cycle traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      miss_q  <= '0;
    end else if (pop_miss) begin
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      if (pop_hit) head_q <= ptr_add(head_q, 1);
      if (do_alloc) tail_q <= ptr_add(tail_q, n_alloc);
      count_q <= CNT_W'(int'(count_q) - int'(pop_hit) + (do_alloc ? n_alloc : 0));
      for (int i = 0; i < DEPTH; i++) begin
        if (res_hit[i]) begin
          done_q[i] <= 1'b1;
          miss_q[i] <= res_miss;
        end
      end
      if (do_alloc && alloc1) begin
        done_q[tail_q] <= 1'b0;
        miss_q[tail_q] <= 1'b0;
      end
      if (do_alloc && alloc2) begin
        done_q[slot2] <= 1'b0;
        miss_q[slot2] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc && alloc1) tag_q[tail_q] <= alloc_tag1;
    if (do_alloc && alloc2) tag_q[slot2]  <= alloc_tag2;
  end

`ifdef SEQ_CHECK_EN
  logic any_match, dbl_res, err_evt;

  function automatic logic is_onehot(input logic [TAG_W-1:0] t);
    return (t != '0) && ((t & (t - 1'b1)) == '0);
  endfunction

  always_comb begin
    any_match = 1'b0;
    dbl_res   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (tag_q[i] == res_tag)) begin
        any_match = 1'b1;
        if (done_q[i]) dbl_res = 1'b1;
      end
    end
    err_evt = normal && !pop_miss &&
              ((res_valid && (!any_match || dbl_res)) ||
               ((alloc1 || alloc2) && !admit) ||
               (alloc1 && !is_onehot(alloc_tag1)) ||
               (alloc2 && !is_onehot(alloc_tag2)));
  end

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (err_evt) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_branch_resolve_sequencer.sv
// Scoreboard bench for branch_resolve_sequencer: expected retirements queued at resolve time,
// popped by a retire monitor; per-scenario tasks check counters, stall and admission inline.
module tb_branch_resolve_sequencer;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic alloc1 = 1'b0, alloc2 = 1'b0;
  logic [TAG_W-1:0] alloc_tag1 = '0, alloc_tag2 = '0;
  logic res_valid = 1'b0, res_miss = 1'b0;
  logic [TAG_W-1:0] res_tag = '0;
  logic alloc_ok, stall, prsuccess, prmiss;
  logic [TAG_W-1:0] head_tag, tagregfix, kill_mask;
  logic [2:0] count;
`ifdef SEQ_CHECK_EN
  logic err;
`endif

  branch_resolve_sequencer #(.TAG_W(5), .DEPTH(4), .RECOVER_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .alloc1(alloc1), .alloc2(alloc2), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .res_valid(res_valid), .res_tag(res_tag), .res_miss(res_miss),
    .alloc_ok(alloc_ok), .stall(stall), .prsuccess(prsuccess), .prmiss(prmiss),
    .head_tag(head_tag), .tagregfix(tagregfix), .kill_mask(kill_mask), .count(count)
`ifdef SEQ_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             miss;
    logic [TAG_W-1:0] kill;
    logic [TAG_W-1:0] fix;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  // Retire monitor: every prsuccess/prmiss must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (prsuccess || prmiss)) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL retire_unexpected: head_tag=%b prmiss=%b, expected no retire", head_tag, prmiss);
      end else begin
        mon_e = sbq.pop_front();
        if (head_tag !== mon_e.tag || prmiss !== mon_e.miss || prsuccess !== !mon_e.miss ||
            (mon_e.miss && (kill_mask !== mon_e.kill || tagregfix !== mon_e.fix))) begin
          n_bad++;
          $display("FAIL retire: got tag=%b miss=%b kill=%b fix=%b, expected tag=%b miss=%b kill=%b fix=%b",
                   head_tag, prmiss, kill_mask, tagregfix, mon_e.tag, mon_e.miss, mon_e.kill, mon_e.fix);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alloc1 = 0; alloc2 = 0; alloc_tag1 = '0; alloc_tag2 = '0;
    res_valid = 0; res_tag = '0; res_miss = 0;
  endtask

  task automatic drive(input logic a1, input logic a2, input logic [TAG_W-1:0] t1,
                       input logic [TAG_W-1:0] t2, input logic rv, input logic [TAG_W-1:0] rt,
                       input logic rm);
    alloc1 = a1; alloc2 = a2; alloc_tag1 = t1; alloc_tag2 = t2;
    res_valid = rv; res_tag = rt; res_miss = rm;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d pending, expected 0", sbq.size());
    end
    sbq.delete();
    idle();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL rst_alloc_ok: got %b expected 1", alloc_ok); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", stall); end
    n_cmp++;
    if ({prsuccess, prmiss, head_tag, tagregfix, kill_mask} !== '0) begin
      n_bad++;
      $display("FAIL rst_outs: got %b/%b/%b/%b/%b expected zeros", prsuccess, prmiss, head_tag, tagregfix, kill_mask);
    end
  endtask

  task automatic test_hit();
    do_reset();
    drive(1, 1, 5'b00010, 5'b00100, 0, '0, 0);
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL hit_count_alloc: got %0d expected 2", count); end
    sbq.push_back('{tag: 5'b00010, miss: 1'b0, kill: '0, fix: '0});
    drive(0, 0, '0, '0, 1, 5'b00010, 0);
    n_cmp++; if (prsuccess !== 1'b1 || head_tag !== 5'b00010) begin
      n_bad++; $display("FAIL hit_pulse: got prsuccess=%b head_tag=%b expected 1/00010", prsuccess, head_tag); end
    tick();
    n_cmp++; if (count !== 3'd1 || prsuccess !== 1'b0) begin
      n_bad++; $display("FAIL hit_after: got count=%0d prsuccess=%b expected 1/0", count, prsuccess); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    drive(1, 1, 5'b00010, 5'b00100, 0, '0, 0);
    drive(0, 0, '0, '0, 1, 5'b00100, 1);
    n_cmp++; if (prsuccess !== 1'b0 || prmiss !== 1'b0) begin
      n_bad++; $display("FAIL ooo_younger_waits: got %b/%b expected 0/0", prsuccess, prmiss); end
    sbq.push_back('{tag: 5'b00010, miss: 1'b0, kill: '0, fix: '0});
    sbq.push_back('{tag: 5'b00100, miss: 1'b1, kill: 5'b00100, fix: 5'b00010});
    drive(0, 0, '0, '0, 1, 5'b00010, 0);
    n_cmp++; if (prsuccess !== 1'b1 || head_tag !== 5'b00010) begin
      n_bad++; $display("FAIL ooo_first: got prsuccess=%b head_tag=%b expected 1/00010", prsuccess, head_tag); end
    tick();
    n_cmp++; if (prmiss !== 1'b1 || tagregfix !== 5'b00010 || kill_mask !== 5'b00100) begin
      n_bad++; $display("FAIL ooo_miss: got prmiss=%b fix=%b kill=%b expected 1/00010/00100", prmiss, tagregfix, kill_mask); end
    tick();
    n_cmp++; if (count !== 3'd0 || stall !== 1'b1) begin
      n_bad++; $display("FAIL ooo_flush: got count=%0d stall=%b expected 0/1", count, stall); end
  endtask

  task automatic test_miss_recover();
    do_reset();
    drive(1, 1, 5'b00010, 5'b00100, 0, '0, 0);
    drive(1, 0, 5'b01000, '0, 0, '0, 0);
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL mr_count: got %0d expected 3", count); end
    sbq.push_back('{tag: 5'b00010, miss: 1'b1, kill: 5'b01110, fix: 5'b00001});
    drive(0, 0, '0, '0, 1, 5'b00010, 1);
    n_cmp++; if (prmiss !== 1'b1 || tagregfix !== 5'b00001 || kill_mask !== 5'b01110) begin
      n_bad++; $display("FAIL mr_miss: got prmiss=%b fix=%b kill=%b expected 1/00001/01110", prmiss, tagregfix, kill_mask); end
    drive(1, 0, 5'b10000, '0, 1, 5'b00100, 0);
    n_cmp++; if (count !== 3'd0 || stall !== 1'b1 || alloc_ok !== 1'b0) begin
      n_bad++; $display("FAIL mr_stall1: got count=%0d stall=%b alloc_ok=%b expected 0/1/0", count, stall, alloc_ok); end
    drive(1, 1, 5'b00001, 5'b00010, 0, '0, 0);
    n_cmp++; if (count !== 3'd0 || stall !== 1'b1) begin
      n_bad++; $display("FAIL mr_stall2: got count=%0d stall=%b expected 0/1", count, stall); end
    tick();
    n_cmp++; if (count !== 3'd0 || stall !== 1'b0 || alloc_ok !== 1'b1) begin
      n_bad++; $display("FAIL mr_release: got count=%0d stall=%b alloc_ok=%b expected 0/0/1", count, stall, alloc_ok); end
  endtask

  task automatic test_full();
    do_reset();
    drive(1, 1, 5'b00001, 5'b00010, 0, '0, 0);
    drive(1, 1, 5'b00100, 5'b01000, 0, '0, 0);
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d expected 4", count); end
    alloc1 = 1; alloc_tag1 = 5'b10000; #1;
    n_cmp++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL full_block: got alloc_ok=%b expected 0", alloc_ok); end
    tick(); idle();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_dropped: got %0d expected 4", count); end
    sbq.push_back('{tag: 5'b00001, miss: 1'b0, kill: '0, fix: '0});
    drive(0, 0, '0, '0, 1, 5'b00001, 0);
    alloc1 = 1; alloc_tag1 = 5'b10000; #1;
    n_cmp++; if (alloc_ok !== 1'b1) begin n_bad++; $display("FAIL full_pop_admit: got alloc_ok=%b expected 1", alloc_ok); end
    tick(); idle();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_pop_count: got %0d expected 4", count); end
    sbq.push_back('{tag: 5'b00010, miss: 1'b0, kill: '0, fix: '0});
    drive(0, 0, '0, '0, 1, 5'b00010, 0);
    alloc1 = 1; alloc2 = 1; alloc_tag1 = 5'b00001; alloc_tag2 = 5'b00001; #1;
    n_cmp++; if (alloc_ok !== 1'b0) begin n_bad++; $display("FAIL full_pair_block: got alloc_ok=%b expected 0", alloc_ok); end
    tick(); idle();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_pair_dropped: got %0d expected 3", count); end
  endtask

  task automatic test_wrap();
    logic [TAG_W-1:0] t;
    do_reset();
    t = 5'b00001;
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, t, '0, 0, '0, 0);
      sbq.push_back('{tag: t, miss: 1'b0, kill: '0, fix: '0});
      drive(0, 0, '0, '0, 1, t, 0);
      tick();
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL wrap_count%0d: got %0d expected 0", k, count); end
      t = {t[TAG_W-2:0], t[TAG_W-1]};
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 5'b00001, 5'b00010, 0, '0, 0);
    drive(1, 0, 5'b00100, '0, 0, '0, 0);
    drive(0, 0, '0, '0, 1, 5'b00100, 0);
    drive(0, 0, '0, '0, 1, 5'b00010, 0);
    drive(0, 0, '0, '0, 1, 5'b00010, 1);
    n_cmp++; if (prsuccess !== 1'b0 || count !== 3'd3) begin
      n_bad++; $display("FAIL b2b_wait: got prsuccess=%b count=%0d expected 0/3", prsuccess, count); end
    drive(0, 0, '0, '0, 1, 5'b10000, 1);
    n_cmp++; if (prsuccess !== 1'b0 || count !== 3'd3) begin
      n_bad++; $display("FAIL b2b_nomatch: got prsuccess=%b count=%0d expected 0/3", prsuccess, count); end
    sbq.push_back('{tag: 5'b00001, miss: 1'b0, kill: '0, fix: '0});
    sbq.push_back('{tag: 5'b00010, miss: 1'b0, kill: '0, fix: '0});
    sbq.push_back('{tag: 5'b00100, miss: 1'b0, kill: '0, fix: '0});
    drive(0, 0, '0, '0, 1, 5'b00001, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (prsuccess !== 1'b1 || count !== 3'(3 - k)) begin
        n_bad++; $display("FAIL b2b_retire%0d: got prsuccess=%b count=%0d expected 1/%0d", k, prsuccess, count, 3 - k); end
      if (k == 0) begin
        res_valid = 1; res_tag = 5'b00010; res_miss = 1;
      end
      tick(); idle();
    end
    n_cmp++; if (prsuccess !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL b2b_end: got prsuccess=%b count=%0d expected 0/0", prsuccess, count); end
  endtask

`ifdef SEQ_CHECK_EN
  task automatic test_err();
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_rst: got %b expected 0", err); end
    drive(0, 0, '0, '0, 1, 5'b10000, 0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", err); end
    tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", err); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b expected 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_out_of_order();
    test_miss_recover();
    test_full();
    test_wrap();
    test_back_to_back();
`ifdef SEQ_CHECK_EN
    test_err();
`endif
    tick();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expected retirements never seen, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
